// File: rtl/eh2_exu_redirect_ctl.sv
// Consumer-side control for the ALU branch-resolution outputs. It holds one pending
// fetch redirect per thread, arbitrates them onto the IFU port, and queues BHT updates.

module eh2_exu_redirect_thr (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        flush_up0,
  input  logic        flush_up1,
  input  logic        flush_low,
  input  logic [30:0] path_i0,
  input  logic [30:0] path_i1,
  input  logic        protect,
  input  logic        retire,
  output logic        pend,
  output logic [30:0] path
);

  // Lower flush wins. An upper flush re-arms the thread even while it retires.
  // The path is frozen only while the thread sits on the IFU port unaccepted.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend <= 1'b0;
      path <= '0;
    end else if (flush_low) begin
      pend <= 1'b0;
    end else if (flush_up0 | flush_up1) begin
      pend <= 1'b1;
      if (!protect) path <= flush_up0 ? path_i0 : path_i1;
    end else if (retire) begin
      pend <= 1'b0;
    end
  end

endmodule

module eh2_exu_redirect_ctl #(
  parameter int NUM_THREADS = 2,
  parameter int BHT_ADDR_W  = 8,
  parameter int UPD_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic [NUM_THREADS-1:0] flush_upper_i0,
  input  logic [30:0]            flush_path_i0,
  input  logic [NUM_THREADS-1:0] flush_upper_i1,
  input  logic [30:0]            flush_path_i1,
  input  logic [NUM_THREADS-1:0] flush_lower,
  input  logic                   upd_valid_i0,
  input  logic [BHT_ADDR_W+3:0]  upd_i0,
  input  logic                   upd_valid_i1,
  input  logic [BHT_ADDR_W+3:0]  upd_i1,
  input  logic                   redir_ready,
  output logic                   redir_valid,
  output logic                   redir_tid,
  output logic [30:0]            redir_path,
  output logic                   bht_upd_valid,
  output logic [BHT_ADDR_W+3:0]  bht_upd,
  output logic                   bht_drop
);

  localparam int UW = BHT_ADDR_W + 4;
  localparam int AW = $clog2(UPD_DEPTH);

  // ---------------- redirect side ----------------
  logic [1:0]       fu0, fu1, fl;
  logic [1:0]       pend;
  logic [1:0][30:0] path;
  logic             lock_on, lock_tid, rr, sel, accept;

  assign fu0 = 2'(flush_upper_i0);
  assign fu1 = 2'(flush_upper_i1);
  assign fl  = 2'(flush_lower);

  for (genvar t = 0; t < 2; t++) begin : g_thr
    if (t < NUM_THREADS) begin : g_on
      eh2_exu_redirect_thr u_thr (
        .clk       (clk),
        .rst_l     (rst_l),
        .flush_up0 (fu0[t]),
        .flush_up1 (fu1[t]),
        .flush_low (fl[t]),
        .path_i0   (flush_path_i0),
        .path_i1   (flush_path_i1),
        .protect   (redir_valid & ~redir_ready & (sel == 1'(t))),
        .retire    (accept & (sel == 1'(t))),
        .pend      (pend[t]),
        .path      (path[t])
      );
    end else begin : g_off
      assign pend[t] = 1'b0;
      assign path[t] = '0;
    end
  end

  // A presented request stays put via the lock. Otherwise round-robin breaks ties.
  always_comb begin
    if (lock_on)     sel = lock_tid;
    else if (&pend)  sel = rr;
    else             sel = pend[1];
  end

  assign redir_valid = |pend;
  assign accept      = redir_valid & redir_ready;
  assign redir_tid   = redir_valid & sel;
  assign redir_path  = redir_valid ? path[sel] : '0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lock_on  <= 1'b0;
      lock_tid <= 1'b0;
      rr       <= 1'b0;
    end else begin
      if (accept || (lock_on && fl[lock_tid])) begin
        lock_on <= 1'b0;
      end else if (redir_valid && !fl[sel]) begin
        lock_on  <= 1'b1;
        lock_tid <= sel;
      end
      if (accept) rr <= ~sel;
    end
  end

  // ---------------- BHT update FIFO ----------------
  logic [UPD_DEPTH-1:0][UW-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [AW:0]                  count, free;
  logic                         pop_mem, head_v, s0v, s1v, keep0, keep1;
  logic [UW-1:0]                head, s0d, s1d;

  // The output register takes the oldest of stored plus incoming entries. Whatever
  // is left is stored in order i0 then i1, and the stored entries are capped at capacity.
  always_comb begin
    pop_mem = (count != '0);
    head_v  = pop_mem | upd_valid_i0 | upd_valid_i1;
    head    = '0;
    s0v     = 1'b0;
    s1v     = 1'b0;
    s0d     = upd_i0;
    s1d     = upd_i1;
    if (pop_mem) begin
      head = mem[rd_ptr];
      s0v  = upd_valid_i0 | upd_valid_i1;
      s0d  = upd_valid_i0 ? upd_i0 : upd_i1;
      s1v  = upd_valid_i0 & upd_valid_i1;
    end else if (upd_valid_i0) begin
      head = upd_i0;
      s0v  = upd_valid_i1;
      s0d  = upd_i1;
    end else if (upd_valid_i1) begin
      head = upd_i1;
    end
    free  = (AW+1)'(UPD_DEPTH) - count + (AW+1)'(pop_mem);
    keep0 = s0v && (free != '0);
    keep1 = s1v && (free >= (AW+1)'(2));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bht_upd_valid <= 1'b0;
      bht_upd       <= '0;
      bht_drop      <= 1'b0;
    end else begin
      bht_upd_valid <= head_v;
      bht_upd       <= head;
      bht_drop      <= (s0v & ~keep0) | (s1v & ~keep1);
      if (pop_mem) rd_ptr <= rd_ptr + AW'(1);
      wr_ptr <= wr_ptr + AW'(keep0) + AW'(keep1);
      count  <= count - (AW+1)'(pop_mem) + (AW+1)'(keep0) + (AW+1)'(keep1);
    end
  end

  always_ff @(posedge clk) begin
    if (keep0) mem[wr_ptr]          <= s0d;
    if (keep1) mem[wr_ptr + AW'(1)] <= s1d;
  end

endmodule
